// File: rtl/sw_array_ctrl.sv
// Sequencer for a Smith-Waterman systolic PE array: clears the PEs, loads the query,
// streams the target and tracks the best tail score. Optional macro: SW_DRAIN_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for start
// CLEAR  | one-cycle clear pulse to all PEs, best score reset
// LOAD_X | accepting query characters into PE query registers
// STREAM | accepting target characters and feeding the array head
// DRAIN  | waiting for the remaining tail results
// DONE   | one-cycle completion pulse
module sw_array_ctrl #(
    parameter int PE_LENGTH = 1024,
    parameter int T_LENGTH  = 1000,
    parameter int SCORE_W   = 16,
    localparam int QW = $clog2(PE_LENGTH + 1),
    localparam int TW = $clog2(T_LENGTH + 1),
    localparam int AW = (PE_LENGTH > 1) ? $clog2(PE_LENGTH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [QW-1:0]      q_len,
    input  logic [TW-1:0]      t_len,
    input  logic               x_valid,
    input  logic [1:0]         x_data,
    output logic               x_ready,
    input  logic               y_valid,
    input  logic [1:0]         y_data,
    output logic               y_ready,
    output logic               arr_clr,
    output logic               x_we,
    output logic [AW-1:0]      x_addr,
    output logic [1:0]         x_wdata,
    output logic [1:0]         arr_y,
    output logic               arr_valid,
    input  logic               tail_valid,
    input  logic [SCORE_W-1:0] tail_score,
    output logic               busy,
    output logic               done,
    output logic [SCORE_W-1:0] best_score,
    output logic               err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        LOAD_X = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t         state, state_nxt;
    logic [QW-1:0]  q_len_r;
    logic [TW-1:0]  t_len_r;
    logic [AW-1:0]  x_cnt;
    logic [TW-1:0]  y_cnt;
    logic [TW-1:0]  tail_cnt;
    logic [TW-1:0]  tail_cnt_nxt;
    logic           start_ok;
    logic           x_hs, x_last;
    logic           y_hs, y_last;
    logic           tail_hit;

    assign start_ok = start && (q_len != '0) && (t_len != '0);

    // Handshakes decoded from the state register so ready/next-state stay loop-free.
    assign x_hs   = x_valid && (state == LOAD_X);
    assign x_last = x_hs && (QW'(x_cnt) == q_len_r - QW'(1));
    assign y_hs   = y_valid && (state == STREAM);
    assign y_last = y_hs && (y_cnt == t_len_r - TW'(1));

    // Results past t_len are dropped so the count never runs beyond the job length.
    assign tail_hit     = tail_valid && ((state == STREAM) || (state == DRAIN))
                          && (tail_cnt < t_len_r);
    assign tail_cnt_nxt = tail_cnt + TW'(tail_hit);

    assign x_we    = x_hs;
    assign x_addr  = x_cnt;
    assign x_wdata = (state == LOAD_X) ? x_data : 2'b00;

`ifdef SW_DRAIN_TIMEOUT_EN
    localparam int DRAIN_LIMIT = PE_LENGTH + 16;
    localparam int DW = $clog2(DRAIN_LIMIT);

    logic [DW-1:0] drain_cnt;
    logic          timeout_hit;
`endif

    always_comb begin
        state_nxt = state;
        arr_clr   = 1'b0;
        x_ready   = 1'b0;
        y_ready   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
`ifdef SW_DRAIN_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = start_ok ? CLEAR : DONE;
                end
            end
            CLEAR: begin
                arr_clr   = 1'b1;
                busy      = 1'b1;
                state_nxt = LOAD_X;
            end
            LOAD_X: begin
                x_ready = 1'b1;
                busy    = 1'b1;
                if (x_last) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                y_ready = 1'b1;
                busy    = 1'b1;
                if (y_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (tail_cnt_nxt == t_len_r) begin
                    state_nxt = DONE;
                end
`ifdef SW_DRAIN_TIMEOUT_EN
                else if (drain_cnt == DW'(DRAIN_LIMIT - 1)) begin
                    state_nxt   = DONE;
                    timeout_hit = 1'b1;
                end
`endif
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            q_len_r    <= '0;
            t_len_r    <= '0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            tail_cnt   <= '0;
            best_score <= '0;
            arr_y      <= 2'b00;
            arr_valid  <= 1'b0;
        end else begin
            state     <= state_nxt;
            arr_valid <= y_hs;
            if (y_hs) begin
                arr_y <= y_data;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        q_len_r <= q_len;
                        t_len_r <= t_len;
                        if (!start_ok) begin
                            best_score <= '0;
                        end
                    end
                end
                CLEAR: begin
                    x_cnt      <= '0;
                    y_cnt      <= '0;
                    tail_cnt   <= '0;
                    best_score <= '0;
                end
                LOAD_X: begin
                    if (x_hs && !x_last) begin
                        x_cnt <= x_cnt + AW'(1);
                    end
                end
                STREAM: begin
                    if (y_hs && !y_last) begin
                        y_cnt <= y_cnt + TW'(1);
                    end
                end
                default: begin
                end
            endcase
            if (tail_hit) begin
                tail_cnt <= tail_cnt_nxt;
                if (tail_score > best_score) begin
                    best_score <= tail_score;
                end
            end
        end
    end

`ifdef SW_DRAIN_TIMEOUT_EN
    // err stays up after the timed-out DONE until the next job starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drain_cnt <= '0;
            err       <= 1'b0;
        end else begin
            drain_cnt <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;
            if ((state == CLEAR) || ((state == IDLE) && start)) begin
                err <= 1'b0;
            end else if (timeout_hit) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/sw_array_ctrl.md
SW_ARRAY_CTRL -- requirements
Module: sw_array_ctrl

Interface
REQ-001 SHALL have parameter PE_LENGTH, default 1024, number of PEs in the systolic array (query length maximum).
REQ-002 SHALL have parameter T_LENGTH, default 1000, maximum target (Y) length.
REQ-003 SHALL have parameter SCORE_W, default 16, score width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse; begins a job when IDLE, ignored otherwise.
REQ-007 q_len  in  clog2(PE_LENGTH+1)  query length, sampled on start.
REQ-008 t_len  in  clog2(T_LENGTH+1)  target length, sampled on start.
REQ-009 x_valid / x_data[1:0] / x_ready  in/in/out  query character stream, valid-ready.
REQ-010 y_valid / y_data[1:0] / y_ready  in/in/out  target character stream, valid-ready.
REQ-011 arr_clr  out  1  one-cycle clear pulse to all PEs.
REQ-012 x_we / x_addr / x_wdata[1:0]  out  1/clog2(PE_LENGTH)/2  PE query-register write port.
REQ-013 arr_y / arr_valid  out  2/1  head-of-array Y character and valid (feeds PE 0 Y_i, valid_i).
REQ-014 tail_valid / tail_score  in  1/SCORE_W  valid_o and score_o of the last active PE.
REQ-015 busy / done / best_score / err  out  1/1/SCORE_W/1  status; done is a one-cycle pulse.

Function
REQ-016 States SHALL be IDLE, CLEAR, LOAD_X, STREAM, DRAIN, DONE.
REQ-017 IDLE->CLEAR on start with q_len>=1 and t_len>=1; start with either length 0 SHALL go directly to DONE with best_score=0.
REQ-018 CLEAR SHALL last exactly one cycle with arr_clr=1, best_score cleared, then LOAD_X.
REQ-019 LOAD_X: x_ready=1; each x_valid&x_ready handshake SHALL assert x_we the same cycle, x_addr = handshake index 0..q_len-1, x_wdata=x_data.
REQ-020 After handshake q_len-1, SHALL enter STREAM next cycle; x_ready=0 outside LOAD_X.
REQ-021 STREAM: y_ready=1; arr_y/arr_valid SHALL be registered, one cycle after each y handshake; arr_valid=0 in cycles without handshake (bubble), arr_y holds.
REQ-022 After handshake t_len-1, SHALL enter DRAIN; y_ready=0 outside STREAM.
REQ-023 Tail counter SHALL increment on each tail_valid in STREAM or DRAIN; best_score SHALL update to tail_score when tail_valid and tail_score>best_score (unsigned compare).
REQ-024 DRAIN->DONE when tail count reaches t_len; tail_valid arriving in the same cycle as the last Y handshake SHALL still be counted.
REQ-025 DONE SHALL last one cycle with done=1, then IDLE; best_score holds until next CLEAR.
REQ-026 busy SHALL be 1 in CLEAR, LOAD_X, STREAM, DRAIN; 0 in IDLE and DONE.
REQ-027 Counters SHALL not wrap: tail_valid beyond t_len SHALL be ignored.

Reset
REQ-028 rst low SHALL asynchronously force IDLE, all counters 0, best_score 0, and arr_clr, x_we, x_ready, y_ready, arr_valid, arr_y, busy, done, err all 0.
REQ-029 rst mid-job SHALL abandon the job with no done pulse; after release, block SHALL accept start normally.

Configuration
REQ-030 Macro SW_DRAIN_TIMEOUT_EN: when defined, DRAIN SHALL count cycles and, if tail count < t_len after PE_LENGTH+16 cycles, go to DONE with err=1 for the done cycle (err cleared on next CLEAR).
REQ-031 Without SW_DRAIN_TIMEOUT_EN, no watchdog exists, DRAIN waits indefinitely, err SHALL be constant 0.

Verification
REQ-032 q_len=4, t_len=3, continuous streams, tail_valid 4 cycles after each arr_valid with scores 2,5,3 -> x_we at addr 0..3, three arr_valid cycles, done once, best_score=5.
REQ-033 y_valid toggling 1,0,1,0,1 with t_len=3 -> arr_valid pattern 1,0,1,0,1 delayed one cycle, done after third tail_valid.
REQ-034 start with t_len=0 -> done next cycle, best_score=0, no arr_clr, no x_we.
REQ-035 rst low during STREAM after 2 of 5 Y characters -> all outputs 0 immediately, no done; subsequent job q_len=1, t_len=1 completes normally.
REQ-036 start pulsed while busy -> ignored, job result unchanged.
REQ-037 With SW_DRAIN_TIMEOUT_EN, PE_LENGTH=8, tail_valid withheld -> done with err=1 exactly 24 cycles after entering DRAIN; without macro, no done.
